// File: rtl/fp_to_int_decoder.sv
// Serial IEEE-754 single to int32 converter, truncating toward zero.
// Shifts the mantissa one bit per cycle; start/done handshake.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// IDLE     | waiting for start
// CLASSIFY | decode operand, resolve special cases or set up shift
// SHIFT    | one-bit shift of the working register per cycle
// SIGN     | apply two's-complement negation for negative operands
// DONE     | one-cycle done pulse; may accept a new start
module fp_to_int_decoder (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] f,
  output logic        busy,
  output logic        done,
  output logic [31:0] result,
  output logic        overflow,
  output logic        inexact
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLASSIFY,
    S_SHIFT,
    S_SIGN,
    S_DONE
  } state_t;

  localparam logic [31:0] INT_MAX = 32'h7FFF_FFFF;
  localparam logic [31:0] INT_MIN = 32'h8000_0000;

  state_t      state_q, state_d;
  logic [31:0] op_q, op_d;
  logic [31:0] work_q, work_d;
  logic [31:0] result_q, result_d;
  logic [4:0]  cnt_q, cnt_d;
  logic        left_q, left_d;
  logic        sticky_q, sticky_d;
  logic        overflow_q, overflow_d;
  logic        inexact_q, inexact_d;

  logic        op_sign;
  logic [7:0]  op_exp;
  logic [22:0] op_frac;

  assign op_sign = op_q[31];
  assign op_exp  = op_q[30:23];
  assign op_frac = op_q[22:0];

  always_comb begin
    state_d    = state_q;
    op_d       = op_q;
    work_d     = work_q;
    result_d   = result_q;
    cnt_d      = cnt_q;
    left_d     = left_q;
    sticky_d   = sticky_q;
    overflow_d = overflow_q;
    inexact_d  = inexact_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        state_d = S_IDLE;
        if (start) begin
          op_d       = f;
          overflow_d = 1'b0;
          inexact_d  = 1'b0;
          sticky_d   = 1'b0;
          state_d    = S_CLASSIFY;
        end
      end

      S_CLASSIFY: begin
        work_d = {8'd0, 1'b1, op_frac};
        if (op_exp == 8'd255) begin
          // NaN saturates positive; only -Inf goes to INT_MIN
          overflow_d = 1'b1;
          result_d   = (op_sign && (op_frac == 23'd0)) ? INT_MIN : INT_MAX;
          state_d    = S_DONE;
        end else if (op_exp < 8'd127) begin
          result_d  = 32'd0;
          inexact_d = (op_q[30:0] != 31'd0);
          state_d   = S_DONE;
        end else if (op_exp >= 8'd158) begin
          if (op_q == 32'hCF00_0000) begin
            result_d = INT_MIN;
          end else begin
            overflow_d = 1'b1;
            result_d   = op_sign ? INT_MIN : INT_MAX;
          end
          state_d = S_DONE;
        end else begin
          if (op_exp >= 8'd150) begin
            left_d = 1'b1;
            cnt_d  = 5'(op_exp - 8'd150);
          end else begin
            left_d = 1'b0;
            cnt_d  = 5'(8'd150 - op_exp);
          end
          state_d = (cnt_d == 5'd0) ? S_SIGN : S_SHIFT;
        end
      end

      S_SHIFT: begin
        if (left_q) begin
          work_d = {work_q[30:0], 1'b0};
        end else begin
          work_d   = {1'b0, work_q[31:1]};
          sticky_d = sticky_q | work_q[0];
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = S_SIGN;
        end
      end

      S_SIGN: begin
        result_d  = op_sign ? (~work_q + 32'd1) : work_q;
        inexact_d = sticky_q;
        state_d   = S_DONE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      op_q       <= 32'd0;
      work_q     <= 32'd0;
      result_q   <= 32'd0;
      cnt_q      <= 5'd0;
      left_q     <= 1'b0;
      sticky_q   <= 1'b0;
      overflow_q <= 1'b0;
      inexact_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      op_q       <= op_d;
      work_q     <= work_d;
      result_q   <= result_d;
      cnt_q      <= cnt_d;
      left_q     <= left_d;
      sticky_q   <= sticky_d;
      overflow_q <= overflow_d;
      inexact_q  <= inexact_d;
    end
  end

  assign busy     = (state_q == S_CLASSIFY) || (state_q == S_SHIFT) || (state_q == S_SIGN);
  assign done     = (state_q == S_DONE);
  assign result   = result_q;
  assign overflow = overflow_q;
  assign inexact  = inexact_q;

endmodule

// File: tb/tb_fp_to_int_decoder.sv
// Self-checking bench for fp_to_int_decoder: arithmetic reference model,
// per-cycle compare process, directed and randomized conversions.
module tb_fp_to_int_decoder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] f = 32'd0;
  logic        busy, done, overflow, inexact;
  logic [31:0] result;

  fp_to_int_decoder dut (
    .clk(clk), .rst(rst), .start(start), .f(f),
    .busy(busy), .done(done), .result(result),
    .overflow(overflow), .inexact(inexact)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [31:0] r;
    logic        ovf;
    logic        inx;
    int          lat;
    int          done_at;
  } exp_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Reference: real value of the float, truncated, range-checked as an integer.
  function automatic exp_t model(input logic [31:0] v);
    exp_t             x;
    bit               s;
    int               e;
    longint unsigned  mant, mag;
    x = '0;
    s = v[31];
    e = int'(v[30:23]);
    mant = 64'(v[22:0]) + 64'h80_0000;
    x.lat = 1;
    if (e == 255) begin
      x.ovf = 1'b1;
      x.r   = (s && v[22:0] == 23'd0) ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else if (e < 127) begin
      x.r   = 32'd0;
      x.inx = (v[30:0] != 31'd0);
    end else if (e > 158) begin
      x.ovf = 1'b1;
      x.r   = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end else begin
      if (e >= 150) begin
        mag = mant << (e - 150);
      end else begin
        mag   = mant >> (150 - e);
        x.inx = (mant % (64'd1 << (150 - e))) != 64'd0;
      end
      if ((!s && mag > 64'h7FFF_FFFF) || (s && mag > 64'h8000_0000)) begin
        x.ovf = 1'b1;
        x.r   = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end else begin
        x.r = 32'(s ? -longint'(mag) : longint'(mag));
      end
      if (e < 158) x.lat = ((e >= 150) ? e - 150 : 150 - e) + 2;
    end
    return x;
  endfunction

  // Compare process: every negedge, against model results queued at acceptance.
  exp_t        q[$];
  logic [31:0] held_r = 32'd0;
  logic        held_o = 1'b0;
  logic        held_i = 1'b0;
  bit          rst_prev = 1'b1;

  always @(negedge clk) begin
    exp_t x;
    if (rst_prev) begin
      chk("reset_result", result, 32'd0);
      chk("reset_overflow", 32'(overflow), 32'd0);
      chk("reset_inexact", 32'(inexact), 32'd0);
      chk("reset_busy", 32'(busy), 32'd0);
      chk("reset_done", 32'(done), 32'd0);
      q.delete();
      held_r = 32'd0;
      held_o = 1'b0;
      held_i = 1'b0;
    end else if (done) begin
      if (q.size() == 0) begin
        fail_now("spurious_done");
      end else begin
        x = q.pop_front();
        chk("result", result, x.r);
        chk("overflow", 32'(overflow), 32'(x.ovf));
        chk("inexact", 32'(inexact), 32'(x.inx));
        chk("done_edge", 32'(cyc), 32'(x.done_at));
        held_r = x.r;
        held_o = x.ovf;
        held_i = x.inx;
      end
    end else begin
      chk("hold_result", result, held_r);
      chk("hold_flags", {30'd0, overflow, inexact}, {30'd0, held_o, held_i});
    end
    if (start && !busy && !rst) begin
      x = model(f);
      x.done_at = cyc + 1 + x.lat;
      q.push_back(x);
      held_o = 1'b0;
      held_i = 1'b0;
    end
    rst_prev = rst;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done;
    for (int i = 0; i < 40; i++) begin
      if (done) return;
      tick();
    end
    fail_now("timeout_waiting_done");
  endtask

  task automatic convert(input logic [31:0] v, input int gap);
    for (int i = 0; i < 60 && busy; i++) tick();
    start = 1'b1;
    f     = v;
    tick();
    start = 1'b0;
    f     = $urandom;
    wait_done();
    repeat (gap) tick();
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog_expired");
    $fatal(1, "watchdog");
  end

  logic [31:0] directed [12] = '{
    32'h4049_0FDB, 32'hC2F6_0000, 32'h4EFF_FFFF, 32'h4F00_0000,
    32'hCF00_0000, 32'hFF80_0000, 32'h7FC0_0000, 32'h3F00_0000,
    32'h0000_0001, 32'h8000_0000, 32'h4B00_0000, 32'hC0A0_0000
  };

  initial begin
    exp_t        m;
    logic [31:0] rv;
    logic [7:0]  re;

    m = model(32'h4049_0FDB);
    chk("model_pi", {m.r[28:0], m.ovf, m.inx, 1'b0}, {29'd3, 1'b0, 1'b1, 1'b0});
    chk("model_pi_lat", 32'(m.lat), 32'd24);
    m = model(32'hC2F6_0000);
    chk("model_m123", m.r, 32'hFFFF_FF85);
    chk("model_m123_lat", 32'(m.lat), 32'd19);
    m = model(32'h4EFF_FFFF);
    chk("model_max_exact", m.r, 32'h7FFF_FF80);
    m = model(32'hCF00_0000);
    chk("model_int_min", {m.r[31:2], m.ovf, m.inx}, {30'h2000_0000, 1'b0, 1'b0});

    rst = 1'b1;
    repeat (3) tick();
    chk("init_result", result, 32'd0);
    chk("init_busy_done", {30'd0, busy, done}, 32'd0);
    rst = 1'b0;
    tick();

    foreach (directed[i]) convert(directed[i], i % 2);

    // start during busy is ignored
    start = 1'b1; f = 32'h4049_0FDB;
    tick();
    start = 1'b0;
    repeat (4) tick();
    start = 1'b1; f = 32'h4F00_0000;
    tick();
    start = 1'b0;
    wait_done();
    tick();

    // reset during SHIFT: no done, everything cleared
    start = 1'b1; f = 32'h4049_0FDB;
    tick();
    start = 1'b0;
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("midreset_result", result, 32'd0);
    chk("midreset_busy", 32'(busy), 32'd0);
    repeat (30) tick();

    // back-to-back with start held through DONE
    start = 1'b1; f = 32'hC2F6_0000;
    tick();
    wait_done();
    f = 32'h3F80_0000;
    tick();
    start = 1'b0;
    wait_done();
    tick();

    for (int n = 0; n < 150; n++) begin
      rv = $urandom;
      case ($urandom_range(0, 3))
        0: ;
        1, 2: begin
          re = 8'($urandom_range(120, 160));
          rv[30:23] = re;
        end
        default: begin
          case ($urandom_range(0, 3))
            0: rv[30:23] = 8'd255;
            1: rv[30:23] = 8'd0;
            2: rv[30:23] = 8'd158;
            default: rv[30:23] = 8'd150;
          endcase
          if ($urandom_range(0, 1) == 0) rv[22:0] = 23'd0;
        end
      endcase
      convert(rv, $urandom_range(0, 2));
    end

    repeat (3) tick();
    if (q.size() != 0) fail_now("pending_results_never_delivered");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fp_to_int_decoder.md
# fp_to_int_decoder

Sequential IEEE-754 single-precision to signed 32-bit integer converter, truncating toward zero. It sits on the output side of the floating-point arithmetic path and turns a float result into a two's-complement integer for the display/BCD stage. It uses a start/done handshake and shifts the mantissa one bit per cycle, the same serial style as the float adder.

## Interface
Parameters: none.
- `clk`  in  1  system clock; all state updates on rising edge
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  request conversion of `f`; sampled only while `busy`=0
- `f`  in  32  IEEE-754 single operand: sign[31], exponent[30:23], fraction[22:0]
- `busy`  out  1  conversion in progress (CLASSIFY, SHIFT, SIGN states)
- `done`  out  1  one-cycle pulse; `result` and flags valid from this cycle
- `result`  out  32  signed integer; held until the next accepted `start`
- `overflow`  out  1  value out of int32 range, or Inf/NaN; `result` is saturated
- `inexact`  out  1  nonzero fraction bits were discarded

## Operation
- Reset: state IDLE; `result`=0, `busy`=0, `done`=0, `overflow`=0, `inexact`=0. Reset wins over every other event, including mid-conversion. No partial result is kept.
- IDLE / DONE: if `start`=1, latch `f` into an internal operand register, clear `overflow`/`inexact`, go to CLASSIFY. `f` is ignored after this latch.
- CLASSIFY: s=sign, e=exponent, m={1,fraction} zero-extended into a 32-bit working register.
  - e=255 (Inf/NaN): `overflow`=1; `result`=0x80000000 if s=1 and fraction=0, else 0x7FFFFFFF, so NaN saturates positive. Go to DONE.
  - e<127, including zero and denormals: `result`=0; `inexact`=1 unless e=0 and fraction=0. Go to DONE. -0 gives 0.
  - e≥158: if `f`==0xCF000000, `result`=0x80000000 exact. Otherwise `overflow`=1 and `result`=0x7FFFFFFF (s=0) or 0x80000000 (s=1). Go to DONE.
  - 127≤e≤157: direction left if e≥150, else right. Shift count n=|e−150|, so n is 0..23 right or 0..7 left. Go to SHIFT if n>0, else SIGN.
- SHIFT: one 1-bit shift of the working register per cycle, n times. On a right shift, if the bit shifted out is 1, set `inexact`=1 (sticky). After the last shift, go to SIGN.
- SIGN: if s=1, `result`=~work+1; else `result`=work. Go to DONE.
- DONE: `done`=1 for exactly this cycle, `busy`=0. Go to IDLE unless `start`=1, which is accepted as in IDLE.
- `start` while `busy`=1 is ignored, with no queueing.
- Width rule: the working register never exceeds 31 magnitude bits in the normal path (max 0x7FFFFF80), so negation cannot overflow.

## Timing
- Edge 0 is the edge that samples `start`. `busy`=1 from after edge 0 until the DONE state.
- Special cases (Inf/NaN, |x|<1, e≥158): `done` high in the cycle after edge 1.
- Normal path: `done` high in the cycle after edge n+2. Worst case n=23 gives `done` after edge 25.
- `result`, `overflow` and `inexact` are registered. They change only on the edge entering DONE (and on an accepted `start` for the flags), and are stable from `done` until the next accepted `start`.
- Back-to-back: `start` held high in the DONE cycle begins the next conversion at that edge, with no idle cycle.

## Test plan
- `f`=0x40490FDB (π) → `result`=0x00000003, `inexact`=1, `overflow`=0; `done` after edge 24 (n=22).
- `f`=0xC2F60000 (−123.0) → `result`=0xFFFFFF85, `inexact`=0; `done` after edge 19. `f`=0x4EFFFFFF → 0x7FFFFF80 via 7 left shifts, exact.
- `f`=0x4F000000 → 0x7FFFFFFF, `overflow`=1. `f`=0xCF000000 → 0x80000000, `overflow`=0. `f`=0xFF800000 → 0x80000000, `overflow`=1. `f`=0x7FC00000 → 0x7FFFFFFF, `overflow`=1. All have `done` after edge 1.
- `f`=0x3F000000 (0.5) → 0, `inexact`=1. `f`=0x00000001 → 0, `inexact`=1. `f`=0x80000000 → 0, `inexact`=0.
- Start π, then pulse `start` with 0x4F000000 at edge 5 → ignored; π result delivered unchanged. Next, assert `rst` during SHIFT → all outputs 0 and IDLE next cycle, with no `done` pulse.
- Hold `start`=1 with `f` changing each conversion (−123.0, then 1.0=0x3F800000) → second conversion starts in the first DONE cycle, giving results 0xFFFFFF85 then 0x00000001 with no idle gap.
